mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 132 +++++++++++++
 tb/tb_mem_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM register, load byte/halfword/word extraction,
// sign/zero extension and write-back select. Drives MEM->WB, MEM->ID forwarding and hi/lo buses.
// Optional feature: define MEM_RDATA_HOLD_EN to capture SRAM read data while MEM is frozen.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [75:0] ex_to_mem_bus,
  input  logic [4:0]  ex_load_bus,
  input  logic [3:0]  data_ram_sel,
  input  logic [65:0] ex_hi_lo_bus,
  input  logic [31:0] data_sram_rdata,
  output logic [69:0] mem_to_wb_bus,
  output logic [37:0] mem_to_rf_bus,
  output logic [65:0] mem_hi_lo_bus
);

  localparam int unsigned ExToMemWd = 76;
  localparam int unsigned LoadBus   = 5;
  localparam int unsigned HiLoWd    = 66;

  logic [ExToMemWd-1:0] ex_mem_q;
  logic [LoadBus-1:0]   load_q;
  logic [3:0]           sel_q;
  logic [HiLoWd-1:0]    hi_lo_q;

  // Bubble: EX/MEM boundary stopped while MEM/WB keeps moving.
  logic bubble;
  logic load_en;
  assign bubble  = stall[3] & ~stall[4];
  assign load_en = ~stall[3];

  // EX/MEM pipeline register: reset, bubble, load or hold.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_mem_q <= '0;
      load_q   <= '0;
      sel_q    <= '0;
      hi_lo_q  <= '0;
    end else if (load_en) begin
      ex_mem_q <= ex_to_mem_bus;
      load_q   <= ex_load_bus;
      sel_q    <= data_ram_sel;
      hi_lo_q  <= ex_hi_lo_bus;
    end
  end

  logic [31:0] pc;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  assign pc         = ex_mem_q[75:44];
  assign sel_rf_res = ex_mem_q[38];
  assign rf_we      = ex_mem_q[37];
  assign rf_waddr   = ex_mem_q[36:32];
  assign ex_result  = ex_mem_q[31:0];

  // RAM enables were consumed in EX; stall bits other than 3/4 belong to other stages.
  logic unused_in;
  assign unused_in = ^{ex_mem_q[43:39], stall[5], stall[2:0]};

  logic [31:0] rdata;

`ifdef MEM_RDATA_HOLD_EN
  logic [31:0] rdata_hold_q;
  logic        held_q;

  // Capture read data on the first frozen cycle so a changing SRAM output cannot disturb MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_hold_q <= '0;
      held_q       <= 1'b0;
    end else if (bubble || load_en) begin
      held_q <= 1'b0;
    end else if (stall[4] && !held_q) begin
      rdata_hold_q <= data_sram_rdata;
      held_q       <= 1'b1;
    end
  end

  assign rdata = held_q ? rdata_hold_q : data_sram_rdata;
`else
  assign rdata = data_sram_rdata;
`endif

  logic [7:0]  byte_val;
  logic        byte_ok;
  logic [15:0] half_val;
  logic        half_ok;
  logic [31:0] load_data;

  // Lane selection and extension; undefined lane selects yield zero.
  always_comb begin
    byte_val  = '0;
    byte_ok   = 1'b1;
    half_val  = '0;
    half_ok   = 1'b1;
    load_data = '0;
    case (sel_q)
      4'b0001: byte_val = rdata[7:0];
      4'b0010: byte_val = rdata[15:8];
      4'b0100: byte_val = rdata[23:16];
      4'b1000: byte_val = rdata[31:24];
      default: byte_ok  = 1'b0;
    endcase
    case (sel_q)
      4'b0011: half_val = rdata[15:0];
      4'b1100: half_val = rdata[31:16];
      default: half_ok  = 1'b0;
    endcase
    if (load_q[4]) begin
      load_data = byte_ok ? {{24{byte_val[7]}}, byte_val} : '0;
    end else if (load_q[3]) begin
      load_data = byte_ok ? {24'h0, byte_val} : '0;
    end else if (load_q[2]) begin
      load_data = half_ok ? {{16{half_val[15]}}, half_val} : '0;
    end else if (load_q[1]) begin
      load_data = half_ok ? {16'h0, half_val} : '0;
    end else if (load_q[0]) begin
      load_data = rdata;
    end
  end

  logic [31:0] rf_wdata;
  assign rf_wdata = sel_rf_res ? load_data : ex_result;

  assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
  assign mem_to_rf_bus = {rf_we, rf_waddr, rf_wdata};
  assign mem_hi_lo_bus = hi_lo_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases with literal expectations plus
// randomized traffic compared every cycle against a field-level behavioural model.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [75:0] ex_to_mem_bus;
  logic [4:0]  ex_load_bus;
  logic [3:0]  data_ram_sel;
  logic [65:0] ex_hi_lo_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_rf_bus;
  logic [65:0] mem_hi_lo_bus;

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .ex_to_mem_bus  (ex_to_mem_bus),
    .ex_load_bus    (ex_load_bus),
    .data_ram_sel   (data_ram_sel),
    .ex_hi_lo_bus   (ex_hi_lo_bus),
    .data_sram_rdata(data_sram_rdata),
    .mem_to_wb_bus  (mem_to_wb_bus),
    .mem_to_rf_bus  (mem_to_rf_bus),
    .mem_hi_lo_bus  (mem_hi_lo_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  localparam logic [4:0] LdNone = 5'b00000;
  localparam logic [4:0] LdB    = 5'b10000;
  localparam logic [4:0] LdBu   = 5'b01000;
  localparam logic [4:0] LdH    = 5'b00100;
  localparam logic [4:0] LdHu   = 5'b00010;
  localparam logic [4:0] LdW    = 5'b00001;

`ifdef MEM_RDATA_HOLD_EN
  localparam bit HoldEn = 1'b1;
`else
  localparam bit HoldEn = 1'b0;
`endif

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Loaded value straight from the load rules: pick the lane by its index, then extend.
  function automatic logic [31:0] exp_load(input logic [4:0] ld, input logic [3:0] sel,
                                           input logic [31:0] r);
    int idx;
    logic [7:0]  b;
    logic [15:0] h;
    idx = -1;
    if (ld == LdB || ld == LdBu) begin
      for (int i = 0; i < 4; i++) if (sel == (4'b0001 << i)) idx = i;
      if (idx < 0) return 32'h0;
      b = 8'(r >> (8 * idx));
      return (ld == LdB) ? {{24{b[7]}}, b} : {24'h0, b};
    end
    if (ld == LdH || ld == LdHu) begin
      if (sel == 4'b0011) idx = 0;
      if (sel == 4'b1100) idx = 1;
      if (idx < 0) return 32'h0;
      h = 16'(r >> (16 * idx));
      return (ld == LdH) ? {{16{h[15]}}, h} : {16'h0, h};
    end
    if (ld == LdW) return r;
    return 32'h0;
  endfunction

  // Model of the instruction currently in MEM, kept as named fields.
  logic [31:0] m_pc, m_res, m_hw;
  logic        m_we, m_selrf, m_held;
  logic [4:0]  m_waddr, m_ld;
  logic [3:0]  m_sel;
  logic [65:0] m_hilo;

  always @(posedge clk) begin
    if (rst || (stall[3] && !stall[4])) begin
      m_pc <= '0; m_res <= '0; m_we <= 1'b0; m_selrf <= 1'b0; m_waddr <= '0;
      m_ld <= '0; m_sel <= '0; m_hilo <= '0; m_held <= 1'b0;
      if (rst) m_hw <= '0;
    end else if (!stall[3]) begin
      m_pc    <= ex_to_mem_bus[75:44];
      m_selrf <= ex_to_mem_bus[38];
      m_we    <= ex_to_mem_bus[37];
      m_waddr <= ex_to_mem_bus[36:32];
      m_res   <= ex_to_mem_bus[31:0];
      m_ld    <= ex_load_bus;
      m_sel   <= data_ram_sel;
      m_hilo  <= ex_hi_lo_bus;
      m_held  <= 1'b0;
    end else if (HoldEn && !m_held) begin
      m_hw   <= data_sram_rdata;
      m_held <= 1'b1;
    end
  end

  // Compare process: outputs against the model every cycle once reset has been applied.
  always @(negedge clk) begin
    logic [31:0] r, wd;
    if (cmp_en) begin
      r  = m_held ? m_hw : data_sram_rdata;
      wd = m_selrf ? exp_load(m_ld, m_sel, r) : m_res;
      chk("model_wb", 128'(mem_to_wb_bus), 128'({m_pc, m_we, m_waddr, wd}));
      chk("model_rf", 128'(mem_to_rf_bus), 128'({m_we, m_waddr, wd}));
      chk("model_hilo", 128'(mem_hi_lo_bus), 128'(m_hilo));
    end
  end

  task automatic put(input logic [31:0] pc, input logic selrf, input logic we,
                     input logic [4:0] wa, input logic [31:0] res, input logic [4:0] ld,
                     input logic [3:0] sel);
    ex_to_mem_bus = {pc, 1'b1, 4'b0000, selrf, we, wa, res};
    ex_load_bus   = ld;
    data_ram_sel  = sel;
    ex_hi_lo_bus  = {2'b11, pc, ~pc};
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  logic [69:0] snap;

  initial begin
    // Literal pins on the model's extraction rules.
    chk("pin_lb", 128'(exp_load(LdB, 4'b0010, 32'h1234F678)), 128'h0000_0000_FFFF_FFF6);
    chk("pin_lhu", 128'(exp_load(LdHu, 4'b1100, 32'h80010002)), 128'h0000_0000_0000_8001);
    chk("pin_lh_bad", 128'(exp_load(LdH, 4'b0110, 32'h80010002)), 128'h0);

    // Reset with busy inputs.
    rst = 1'b1; stall = 6'b0; data_sram_rdata = 32'hFFFF_FFFF;
    put(32'hABCD_0000, 1'b1, 1'b1, 5'd17, 32'h1234_5678, LdW, 4'b1111);
    cyc(); cmp_en = 1'b1;
    chk("rst_wb", 128'(mem_to_wb_bus), 128'h0);
    chk("rst_hilo", 128'(mem_hi_lo_bus), 128'h0);
    cyc();
    chk("rst_rf", 128'(mem_to_rf_bus), 128'h0);
    #1 rst = 1'b0;
    put(32'hABCD_0000, 1'b0, 1'b1, 5'd17, 32'h1234_5678, LdNone, 4'b0000);
    #1 chk("rst_release_we", 128'(mem_to_rf_bus[37]), 128'h0);

    // Byte loads.
    put(32'h100, 1'b1, 1'b1, 5'd3, 32'h1001, LdB, 4'b0010);
    data_sram_rdata = 32'h12F4_5678;
    cyc();
    chk("lb_pos", 128'(mem_to_rf_bus), 128'({1'b1, 5'd3, 32'h0000_0056}));
    chk("lb_pc", 128'(mem_to_wb_bus[69:38]), 128'h100);
    #1 put(32'h104, 1'b1, 1'b1, 5'd3, 32'h1001, LdB, 4'b0010);
    data_sram_rdata = 32'h1234_F678;
    cyc();
    chk("lb_neg", 128'(mem_to_rf_bus[31:0]), 128'hFFFF_FFF6);
    #1 put(32'h108, 1'b1, 1'b1, 5'd3, 32'h1001, LdBu, 4'b0010);
    cyc();
    chk("lbu", 128'(mem_to_rf_bus[31:0]), 128'h0000_00F6);

    // Halfword loads.
    data_sram_rdata = 32'h8001_0002;
    #1 put(32'h10C, 1'b1, 1'b1, 5'd4, 32'h2002, LdH, 4'b1100);
    cyc();
    chk("lh_hi", 128'(mem_to_rf_bus[31:0]), 128'hFFFF_8001);
    #1 put(32'h110, 1'b1, 1'b1, 5'd4, 32'h2002, LdHu, 4'b1100);
    cyc();
    chk("lhu_hi", 128'(mem_to_rf_bus[31:0]), 128'h0000_8001);
    #1 put(32'h114, 1'b1, 1'b1, 5'd4, 32'h2000, LdH, 4'b0011);
    cyc();
    chk("lh_lo", 128'(mem_to_rf_bus[31:0]), 128'h0000_0002);
    #1 put(32'h118, 1'b1, 1'b1, 5'd4, 32'h2000, LdHu, 4'b0011);
    cyc();
    chk("lhu_lo", 128'(mem_to_rf_bus[31:0]), 128'h0000_0002);

    // Non-load result ignores read data.
    #1 put(32'h200, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, LdNone, 4'b0000);
    cyc();
    chk("alu_rf", 128'(mem_to_rf_bus), 128'({1'b1, 5'd5, 32'hDEAD_BEEF}));
    #1 data_sram_rdata = 32'h5A5A_A5A5;
    #1 chk("alu_rf_rdata", 128'(mem_to_rf_bus), 128'({1'b1, 5'd5, 32'hDEAD_BEEF}));

    // Bubble.
    stall = 6'b001000;
    cyc();
    chk("bubble_we", 128'(mem_to_wb_bus[37]), 128'h0);
    chk("bubble_pc", 128'(mem_to_wb_bus[69:38]), 128'h0);

    // Full freeze of EX/MEM and MEM/WB keeps outputs.
    #1 stall = 6'b000000;
    put(32'h300, 1'b0, 1'b1, 5'd7, 32'hCAFE_F00D, LdNone, 4'b0000);
    cyc();
    snap = {32'h300, 1'b1, 5'd7, 32'hCAFE_F00D};
    chk("freeze_entry", 128'(mem_to_wb_bus), 128'(snap));
    #1 stall = 6'b011000;
    put(32'hFFFF_0000, 1'b1, 1'b0, 5'd31, 32'h0BAD_0BAD, LdW, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("freeze_hold", 128'(mem_to_wb_bus), 128'(snap));
    end

    // Read-data hold across a frozen lw.
    #1 stall = 6'b000000;
    put(32'h400, 1'b1, 1'b1, 5'd9, 32'h44, LdW, 4'b1111);
    data_sram_rdata = 32'h1111_1111;
    cyc();
    chk("hold_first", 128'(mem_to_rf_bus[31:0]), 128'h1111_1111);
    #1 stall = 6'b011000;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1 data_sram_rdata = 32'h2222_2222;
      #1 chk("hold_rdata", 128'(mem_to_rf_bus[31:0]),
             HoldEn ? 128'h1111_1111 : 128'h2222_2222);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int kind, s;
      logic [4:0] ld;
      logic [3:0] sel;
      cyc();
      #1;
      kind = $urandom_range(0, 5);
      ld   = (kind == 0) ? LdNone : (LdB >> (kind - 1));
      if (ld == LdB || ld == LdBu) sel = 4'b0001 << $urandom_range(0, 3);
      else if (ld == LdH || ld == LdHu)
        sel = ($urandom_range(0, 7) == 0) ? 4'b0110
              : ($urandom_range(0, 1) == 1 ? 4'b0011 : 4'b1100);
      else sel = 4'($urandom);
      ex_to_mem_bus = {$urandom, 12'($urandom), $urandom};
      ex_load_bus   = ld;
      data_ram_sel  = sel;
      ex_hi_lo_bus  = {2'($urandom), $urandom, $urandom};
      if ($urandom_range(0, 3) != 0) data_sram_rdata = $urandom;
      s = $urandom_range(0, 7);
      stall = (s < 4) ? 6'b000000 : (s == 4) ? 6'b001000 : (s == 7) ? 6'b010000 : 6'b011000;
      stall = stall | (6'($urandom) & 6'b100111);
      rst = ($urandom_range(0, 40) == 0);
    end
    cyc();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
